// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU byte-bus responder: I/O window decode and size defaults.
package mem_io_responder_pkg;

    localparam int IO_DEC_W = 18;

    localparam logic [1:0]          IO_SEL       = 2'b11;
    localparam logic [IO_DEC_W-1:0] IO_UART_ADDR = 18'h30000;
    localparam logic [IO_DEC_W-1:0] IO_CLK_ADDR  = 18'h30004;

    localparam int RAM_AW_DEF  = 17;
    localparam int FIFO_AW_DEF = 3;

endpackage

// File: rtl/mem_io_responder_bus_byte_fifo.sv
// Synchronous 8-bit FIFO; push refused when full, pop ignored when empty, head is combinational.
module bus_byte_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: 2^RAM_AW byte RAM plus UART FIFOs, cycle counter and stop flag in the I/O window.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW  = RAM_AW_DEF,
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);

    logic [7:0]          ram [2**RAM_AW];
    logic [IO_DEC_W-1:0] addr;
    logic                io;
    logic                uart_sel;
    logic                clk_sel;
    logic                clk0_sel;
    logic                rd;
    logic                wr;
    logic                rx_pop;
    logic                tx_push;
    logic [7:0]          tx_push_data;
    logic [7:0]          rx_head;
    logic                rx_full;
    logic                rx_empty;
    logic                tx_full;
    logic                tx_empty;
    logic [FIFO_AW:0]    rx_count;
    logic [FIFO_AW:0]    tx_count;
    logic [31:0]         cnt;
    logic [31:0]         cnt_next;
    logic [31:8]         snap;
    logic                unused_bits;

    assign addr        = mem_a[IO_DEC_W-1:0];
    assign unused_bits = ^{mem_a[31:IO_DEC_W], rx_count, tx_count};
    assign io          = (addr[IO_DEC_W-1 -: 2] == IO_SEL);
    assign uart_sel    = (addr == IO_UART_ADDR);
    assign clk_sel     = (addr[IO_DEC_W-1:2] == IO_CLK_ADDR[IO_DEC_W-1:2]);
    assign clk0_sel    = (addr == IO_CLK_ADDR);

    // Stall only on FIFO state registered at the start of the cycle.
    always_comb begin
        rdy_out = 1'b1;
        if (uart_sel && !mem_wr && rx_empty)                      rdy_out = 1'b0;
        if (uart_sel && mem_wr && (mem_dout != 8'h00) && tx_full) rdy_out = 1'b0;
        if (clk0_sel && mem_wr && tx_full)                        rdy_out = 1'b0;
    end

    assign rd           = rdy_out && !mem_wr;
    assign wr           = rdy_out && mem_wr;
    assign rx_pop       = rd && uart_sel;
    assign tx_push      = wr && ((uart_sel && (mem_dout != 8'h00)) || clk0_sel);
    assign tx_push_data = clk0_sel ? 8'h00 : mem_dout;
    assign cnt_next     = cnt + 32'd1;
    assign rx_ready     = !rx_full;
    assign tx_valid     = !tx_empty;

    bus_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    bus_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt       <= '0;
            snap      <= '0;
            prog_stop <= 1'b0;
            mem_din   <= 8'h00;
        end else begin
            cnt <= cnt_next;
            if (wr && clk0_sel) prog_stop <= 1'b1;
            if (rd) begin
                if (!io) begin
                    mem_din <= ram[addr[RAM_AW-1:0]];
                end else if (uart_sel) begin
                    mem_din <= rx_head;
                end else if (clk_sel) begin
                    // Byte 0 read latches the post-edge counter so bytes 1..3 stay coherent.
                    case (addr[1:0])
                        2'd0: begin
                            mem_din <= cnt_next[7:0];
                            snap    <= cnt_next[31:8];
                        end
                        2'd1:    mem_din <= snap[15:8];
                        2'd2:    mem_din <= snap[23:16];
                        default: mem_din <= snap[31:24];
                    endcase
                end else begin
                    mem_din <= 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr && !io && !rst_in) ram[addr[RAM_AW-1:0]] <= mem_dout;
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, counter, UART FIFOs, stop flag and async reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        prog_stop;

    int n_chk = 0;
    int n_err = 0;

    mem_io_responder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .rdy_out   (rdy_out),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .prog_stop (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
    endtask

    initial begin
        #3;
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_rdy", rdy_out, 1'b1);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_prog_stop", prog_stop, 1'b0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Counter: present 0x30004 while counter holds 0x1FF.
        repeat (511) tick();
        bus(32'h30004, 1'b0, 8'h00);
        tick();
        chk("clk_b0", mem_din, 8'h00);
        bus(32'h30005, 1'b0, 8'h00);
        tick();
        chk("clk_b1", mem_din, 8'h02);
        bus(32'h30006, 1'b0, 8'h00);
        tick();
        chk("clk_b2", mem_din, 8'h00);
        bus(32'h30007, 1'b0, 8'h00);
        tick();
        chk("clk_b3", mem_din, 8'h00);
        bus(32'h30004, 1'b0, 8'h00);
        tick();
        chk("clk_b0_again", mem_din, 8'h04);

        // RAM round trip.
        bus(32'h00010, 1'b1, 8'hA5);
        #1 chk("ram_wr_rdy", rdy_out, 1'b1);
        tick();
        chk("ram_wr_hold", mem_din, 8'h04);
        bus(32'h00010, 1'b0, 8'h00);
        #1 chk("ram_rd_rdy", rdy_out, 1'b1);
        tick();
        chk("ram_rd_10", mem_din, 8'hA5);
        bus(32'h30010, 1'b0, 8'h00);
        tick();
        chk("io_other_rd", mem_din, 8'h00);
        bus(32'h1FFFF, 1'b1, 8'h3C);
        tick();
        bus(32'h1FFFF, 1'b0, 8'h00);
        tick();
        chk("ram_rd_1ffff", mem_din, 8'h3C);

        // RX stall until a byte arrives.
        bus(32'h30000, 1'b0, 8'h00);
        #1 chk("rx_stall_c1", rdy_out, 1'b0);
        tick();
        chk("rx_stall_c2", rdy_out, 1'b0);
        chk("rx_stall_hold", mem_din, 8'h3C);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        #1 chk("rx_stall_c3", rdy_out, 1'b0);
        tick();
        rx_valid = 1'b0;
        #1 chk("rx_go", rdy_out, 1'b1);
        tick();
        chk("rx_data_41", mem_din, 8'h41);
        chk("rx_empty_again", rdy_out, 1'b0);
        bus(32'h00010, 1'b0, 8'h00);

        // RX full: eight bytes fill it, a ninth is refused even alongside a pop.
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h50 + 8'(i);
            tick();
        end
        chk("rx_full", rx_ready, 1'b0);
        rx_data = 8'h58;
        bus(32'h30000, 1'b0, 8'h00);
        #1 chk("rx_pop_rdy", rdy_out, 1'b1);
        tick();
        rx_valid = 1'b0;
        chk("rx_pop_0", mem_din, 8'h50);
        chk("rx_ready_after_pop", rx_ready, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("rx_pop_%0d", i), mem_din, 8'h50 + 32'(i));
        end
        chk("rx_refused_push", rdy_out, 1'b0);
        bus(32'h00010, 1'b0, 8'h00);

        // TX full, zero write, drain.
        for (int i = 1; i <= 8; i++) begin
            bus(32'h30000, 1'b1, 8'(i));
            #1 chk($sformatf("tx_push_rdy_%0d", i), rdy_out, 1'b1);
            tick();
        end
        chk("tx_valid_full", tx_valid, 1'b1);
        bus(32'h30000, 1'b1, 8'h09);
        #1 chk("tx_full_stall", rdy_out, 1'b0);
        tick();
        bus(32'h30000, 1'b1, 8'h00);
        #1 chk("tx_zero_rdy", rdy_out, 1'b1);
        tick();
        bus(32'h30000, 1'b1, 8'h09);
        tx_ready = 1'b1;
        #1 chk("tx_still_full", rdy_out, 1'b0);
        chk("tx_head_1", tx_data, 8'h01);
        tick();
        chk("tx_room", rdy_out, 1'b1);
        chk("tx_head_2", tx_data, 8'h02);
        tick();
        bus(32'h00010, 1'b0, 8'h00);
        for (int k = 3; k <= 9; k++) begin
            chk($sformatf("tx_drain_valid_%0d", k), tx_valid, 1'b1);
            chk($sformatf("tx_drain_%0d", k), tx_data, 32'(k));
            tick();
        end
        chk("tx_drained", tx_valid, 1'b0);

        // Stop flag.
        tx_ready = 1'b0;
        bus(32'h30004, 1'b1, 8'h7F);
        #1 chk("stop_rdy", rdy_out, 1'b1);
        tick();
        chk("stop_set", prog_stop, 1'b1);
        chk("stop_tx_valid", tx_valid, 1'b1);
        chk("stop_tx_zero", tx_data, 8'h00);
        bus(32'h00010, 1'b0, 8'h00);
        tick();
        tick();
        chk("stop_sticky", prog_stop, 1'b1);
        chk("pre_rst_din", mem_din, 8'hA5);

        // Async reset during a stalled RX read with three bytes queued in TX.
        bus(32'h30000, 1'b1, 8'h11);
        tick();
        bus(32'h30000, 1'b1, 8'h12);
        tick();
        bus(32'h00010, 1'b0, 8'h00);
        tick();
        bus(32'h30000, 1'b0, 8'h00);
        #1 chk("pre_rst_stall", rdy_out, 1'b0);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_mem_din", mem_din, 8'h00);
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_prog_stop", prog_stop, 1'b0);
        chk("arst_rx_ready", rx_ready, 1'b1);
        bus(32'h00010, 1'b0, 8'h00);
        tick();
        rst_in = 1'b0;
        tick();
        chk("post_rst_tx_valid", tx_valid, 1'b0);
        chk("post_rst_prog_stop", prog_stop, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU byte memory bus: it answers the core's mem_a / mem_wr / mem_dout requests and drives the mem_din data.
- Contains 128 KB of byte RAM, with 1-cycle read latency and same-cycle writes.
- Decodes the I/O window (mem_a[17:16]==2'b11): UART RX/TX byte FIFOs, a cycle counter and the program-stop flag.
- Drives the CPU's rdy_in, pausing the core when an I/O access cannot complete.

Parameters:
RAM_AW, 17, RAM byte-address width; depth is 2^RAM_AW bytes.
FIFO_AW, 3, log2 depth of each UART FIFO (default depth 8).

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-high reset
mem_a  in  32  CPU address; only bits 17:0 are decoded
mem_wr  in  1  1 = write, 0 = read
mem_dout  in  8  write data from the CPU
mem_din  out  8  read data to the CPU, registered
rdy_out  out  1  to the CPU's rdy_in; low = CPU pauses and holds its request
rx_valid  in  1  UART receiver byte present
rx_data  in  8  UART receiver byte
rx_ready  out  1  RX FIFO can accept a byte
tx_valid  out  1  TX FIFO has a byte for the UART transmitter
tx_data  out  8  head byte of the TX FIFO
tx_ready  in  1  transmitter takes the head byte this cycle
prog_stop  out  1  sticky; set by a write to 0x30004

Behaviour:
- Reset (async, active high): mem_din=0, both FIFOs empty, cycle counter=0, snapshot=0, prog_stop=0. Hence tx_valid=0, rx_ready=1, rdy_out=1. Reset mid-access discards the access and all FIFO contents.
- Decode: io = (mem_a[17:16]==2'b11); otherwise RAM address = mem_a[RAM_AW-1:0].
- An access is accepted in a cycle only when rdy_out=1. When rdy_out=0, no state changes for that access; the CPU re-presents it.
- rdy_out is combinational, computed from registered FIFO counts only:
  - low on a read of 0x30000 while RX FIFO is empty;
  - low on a write of 0x30000 with nonzero data while TX FIFO is full;
  - low on a write of 0x30004 while TX FIFO is full;
  - high otherwise.
- RAM write: byte stored at the clock edge of the request cycle.
- RAM read: mem_din updated at the edge, so it is valid the cycle after the request. Read after write to the same address in consecutive cycles returns the new byte.
- mem_din holds its last value on write cycles and when no access is accepted.
- 0x30000 read: pop the RX head into mem_din.
- 0x30000 write: push mem_dout to TX FIFO; a 0x00 write is ignored and never stalls.
- 0x30004..0x30007 read: return counter byte 0..3, little-endian.
  - Reading 0x30004 captures a snapshot of the counter at that edge and returns byte 0 of the new value.
  - 0x30005..7 return bytes 1..3 of the snapshot.
- 0x30004 write: set prog_stop and push 0x00 to TX regardless of data.
- Any other I/O address: reads return 0x00, writes are ignored.
- Cycle counter: 32-bit, +1 every clock after reset, wraps 0xFFFFFFFF -> 0. Independent of rdy_out.
- RX FIFO:
  - rx_ready = !full, based on the count at the start of the cycle.
  - A push when full is refused, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when nonempty: count unchanged.
  - A pop from empty never happens (read stalls), even if a push arrives that cycle.
- TX FIFO: tx_valid = !empty; the pop occurs when tx_valid & tx_ready. Push/pop rules mirror RX.
- FIFO pointers are FIFO_AW bits and wrap modulo depth; the count is FIFO_AW+1 bits, range 0..2^FIFO_AW.

Decomposition:
- Shared package holds:
  - constants IO_SEL=2'b11, IO_UART_ADDR=18'h30000, IO_CLK_ADDR=18'h30004;
  - the io-decode width;
  - the RAM_AW and FIFO_AW defaults.
- One natural sub-module, bus_byte_fifo: synchronous 8-bit FIFO with push/pop/full/empty/count, instantiated for RX and TX.
- RAM array, decode, counter/snapshot and rdy logic stay in the top.

Test Plan:
- RAM round trip: write 0xA5 @0x00010, then read @0x00010 -> mem_din=0xA5 one cycle after the read request, rdy_out=1 throughout; read of @0x1FFFF after writing 0x3C -> 0x3C.
- RX stall: read 0x30000 with RX empty -> rdy_out=0 for 3 cycles; rx_valid/rx_data=0x41 pushed on cycle 3 -> rdy_out=1 next cycle, then mem_din=0x41 the cycle after, RX empty.
- TX full and zero writes:
  - push 8 bytes 0x01..0x08 with tx_ready=0 -> 9th write (0x09) holds rdy_out=0;
  - write 0x00 -> rdy_out=1, no push;
  - tx_ready=1 -> bytes drain in order 0x01..0x09.
- Counter read: reset, read 0x30004 at counter value 0x000001FF -> mem_din=0x00 (low byte of 0x00000200 at the edge); 0x30005 -> 0x02; 0x30006/7 -> 0x00 despite the counter advancing.
- Stop: write 0x30004 (data 0x7F) -> prog_stop=1 and stays 1; TX receives 0x00.
- Async reset during a stalled RX read with 3 bytes queued in TX -> outputs return to reset values immediately, without waiting for a clock edge; tx_valid=0, prog_stop=0.
